// File: rtl/bp_pkg.sv
// Shared types and constants for the branch predictor.
//   bpEntry_t     : one BTB entry (valid, tag, target, direction counter)
//   CTR_WEAK_T/NT : direction counter encodings for a given counter width
//   PERF_MAX      : saturation value of the performance counters
// Entry fields are sized for the widest supported configuration
// (DATA_WIDTH <= BP_MAX_DW, CTR_BITS <= BP_MAX_CTR); narrower instances
// store their values zero-extended.
package bp_pkg;

  localparam int unsigned BP_MAX_DW  = 32;
  localparam int unsigned BP_MAX_CTR = 8;

  localparam logic [31:0] PERF_MAX = 32'hFFFF_FFFF;

  typedef struct packed {
    logic                  valid;
    logic [BP_MAX_DW-1:0]  tag;
    logic [BP_MAX_DW-1:0]  target;
    logic [BP_MAX_CTR-1:0] ctr;
  } bpEntry_t;

  // Weakly taken: MSB set, all lower bits clear.
  function automatic logic [BP_MAX_CTR-1:0] CTR_WEAK_T(input int unsigned ctrBits);
    return BP_MAX_CTR'(1) << (ctrBits - 1);
  endfunction

  // Weakly not-taken: MSB clear, all lower bits set.
  function automatic logic [BP_MAX_CTR-1:0] CTR_WEAK_NT(input int unsigned ctrBits);
    return CTR_WEAK_T(ctrBits) - BP_MAX_CTR'(1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup, execute-training and performance signals of the branch
// predictor. The "slave" modport is the predictor itself, the "master"
// modport is the pipeline (fetch and execute stages) driving it.
interface branch_predictor_if #(
  parameter int DATA_WIDTH = 32
);

  logic [DATA_WIDTH-1:0] PCF;
  logic                  PredTakenF;
  logic [DATA_WIDTH-1:0] PredTargetF;

  logic                  ClearBP;
  logic                  UpdateE;
  logic [DATA_WIDTH-1:0] PCE;
  logic                  TakenE;
  logic [DATA_WIDTH-1:0] TargetE;
  logic                  PredTakenE;
  logic [DATA_WIDTH-1:0] PredTargetE;
  logic                  MispredictE;
  logic [DATA_WIDTH-1:0] RedirectPCE;

  logic [31:0]           BranchCount;
  logic [31:0]           MispredCount;

  modport master (
    output PCF, ClearBP, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MispredCount
  );

  modport slave (
    input  PCF, ClearBP, UpdateE, PCE, TakenE, TargetE, PredTakenE, PredTargetE,
    output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BranchCount, MispredCount
  );

endinterface

// File: rtl/bp_sat_counter.sv
// Combinational next value of a saturating up/down counter.
//   value     : current counter value
//   inc       : 1 = count up, 0 = count down
//   nextValue : value +/- 1, held at all-ones / zero instead of wrapping
module bp_sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] value,
  input  logic                inc,
  output logic [CTR_BITS-1:0] nextValue
);

  always_comb begin
    nextValue = value;
    if (inc) begin
      if (value != '1) nextValue = value + CTR_BITS'(1);
    end else begin
      if (value != '0) nextValue = value - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: direct-mapped BTB with per-entry saturating
// direction counters, execute-stage mispredict/redirect decision and
// saturating performance counters.
//   clk, rst : clock, asynchronous active-high reset
//   bp       : slave side of branch_predictor_if
//              fetch   : PCF -> PredTakenF, PredTargetF (combinational)
//              execute : UpdateE/PCE/TakenE/TargetE/PredTakenE/PredTargetE
//                        -> MispredictE, RedirectPCE; trains the table
//              control : ClearBP invalidates all entries
//              perf    : BranchCount, MispredCount
module branch_predictor
  import bp_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ENTRIES    = 16,
  parameter int CTR_BITS   = 2
) (
  input logic               clk,
  input logic               rst,
  branch_predictor_if.slave bp
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = DATA_WIDTH - IDX_W - 2;

  localparam logic [BP_MAX_CTR-1:0] RESET_CTR = CTR_WEAK_NT(CTR_BITS);
  localparam logic [BP_MAX_CTR-1:0] ALLOC_CTR = CTR_WEAK_T(CTR_BITS);

  // Register array rather than RAM: the fetch-side read is asynchronous.
  bpEntry_t btb [ENTRIES];

  logic [31:0] branchCount;
  logic [31:0] mispredCount;

  // Fetch-side lookup
  logic [IDX_W-1:0]    idxF;
  logic [TAG_W-1:0]    tagF;
  bpEntry_t            entryF;
  logic [CTR_BITS-1:0] ctrF;
  logic                hitF;

  assign idxF   = bp.PCF[IDX_W+1:2];
  assign tagF   = bp.PCF[DATA_WIDTH-1:IDX_W+2];
  assign entryF = btb[idxF];
  assign ctrF   = CTR_BITS'(entryF.ctr);
  assign hitF   = entryF.valid && (entryF.tag == BP_MAX_DW'(tagF));

  assign bp.PredTakenF  = hitF && ctrF[CTR_BITS-1];
  assign bp.PredTargetF = bp.PredTakenF ? DATA_WIDTH'(entryF.target)
                                        : bp.PCF + DATA_WIDTH'(4);

  // Execute-side training
  logic [IDX_W-1:0]    idxE;
  logic [TAG_W-1:0]    tagE;
  bpEntry_t            entryE;
  logic [CTR_BITS-1:0] ctrE;
  logic [CTR_BITS-1:0] ctrNextE;
  logic                hitE;

  assign idxE   = bp.PCE[IDX_W+1:2];
  assign tagE   = bp.PCE[DATA_WIDTH-1:IDX_W+2];
  assign entryE = btb[idxE];
  assign ctrE   = CTR_BITS'(entryE.ctr);
  assign hitE   = entryE.valid && (entryE.tag == BP_MAX_DW'(tagE));

  bp_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) uCtr (
    .value     (ctrE),
    .inc       (bp.TakenE),
    .nextValue (ctrNextE)
  );

  // Instruction addresses are word aligned; the low bits never select anything.
  logic unusedPcBits;
  assign unusedPcBits = ^{bp.PCF[1:0], bp.PCE[1:0]};

  // Mispredict / redirect
  assign bp.MispredictE = bp.UpdateE &&
                          ((bp.PredTakenE != bp.TakenE) ||
                           (bp.TakenE && (bp.PredTargetE != bp.TargetE)));

  assign bp.RedirectPCE = bp.TakenE ? bp.TargetE : bp.PCE + DATA_WIDTH'(4);

  // Table state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid  <= 1'b0;
        btb[i].tag    <= '0;
        btb[i].target <= '0;
        btb[i].ctr    <= RESET_CTR;
      end
    end else if (bp.ClearBP) begin
      // Tags and targets are left as-is; valid=0 hides them.
      for (int i = 0; i < ENTRIES; i++) begin
        btb[i].valid <= 1'b0;
        btb[i].ctr   <= RESET_CTR;
      end
    end else if (bp.UpdateE) begin
      if (hitE) begin
        btb[idxE].ctr <= BP_MAX_CTR'(ctrNextE);
        if (bp.TakenE) btb[idxE].target <= BP_MAX_DW'(bp.TargetE);
      end else if (bp.TakenE) begin
        // Miss on a taken branch evicts whatever shares the index.
        btb[idxE].valid  <= 1'b1;
        btb[idxE].tag    <= BP_MAX_DW'(tagE);
        btb[idxE].target <= BP_MAX_DW'(bp.TargetE);
        btb[idxE].ctr    <= ALLOC_CTR;
      end
    end
  end

  // Performance counters keep counting through ClearBP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branchCount  <= '0;
      mispredCount <= '0;
    end else begin
      if (bp.UpdateE && (branchCount != PERF_MAX))
        branchCount <= branchCount + 32'd1;
      if (bp.MispredictE && (mispredCount != PERF_MAX))
        mispredCount <= mispredCount + 32'd1;
    end
  end

  assign bp.BranchCount  = branchCount;
  assign bp.MispredCount = mispredCount;

endmodule
